// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite capture/render image path.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } writer_state_t;

  // Top bit of each colour field inside a {R,G,B} 24-bit pixel.
  localparam int R_HI = 23;
  localparam int G_HI = 15;
  localparam int B_HI = 7;

  function automatic logic [7:0] rgb332(input logic [23:0] rgb);
    return {rgb[R_HI -: 3], rgb[G_HI -: 3], rgb[B_HI -: 2]};
  endfunction

endpackage

// File: rtl/sprite_window_addr.sv
// Window hit test and local (bank-relative) address for a sprite-sized region.
module sprite_window_addr #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int AW     = $clog2(WIDTH*HEIGHT)
) (
  input  logic [10:0]   x,
  input  logic [9:0]    y,
  input  logic [10:0]   h,
  input  logic [9:0]    v,
  output logic          hit,
  output logic [AW-1:0] local_addr
);

  localparam int LXW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int LYW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  // 12-bit arithmetic so a window hanging past column 2047 never wraps to 0.
  logic [11:0]    h12, x12, v12, y12;
  logic [LXW-1:0] lx;
  logic [LYW-1:0] ly;

  assign h12 = {1'b0, h};
  assign x12 = {1'b0, x};
  assign v12 = {2'b00, v};
  assign y12 = {2'b00, y};

  assign hit = (h12 >= x12) && (h12 < x12 + 12'(WIDTH)) &&
               (v12 >= y12) && (v12 < y12 + 12'(HEIGHT));

  assign lx = LXW'(h12 - x12);
  assign ly = LYW'(v12 - y12);

  assign local_addr = AW'(ly) * AW'(WIDTH) + AW'(lx);

endmodule

// File: rtl/sprite_image_writer.sv
// Crops a window from a raster RGB888 stream, quantizes to RGB332 and writes it
// into the back bank of a two-bank image BRAM, swapping banks on a full frame.
module sprite_image_writer
  import sprite_pkg::*;
#(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int ADDR_W = $clog2(WIDTH*HEIGHT)+1
) (
  input  logic              pixel_clk_in,
  input  logic              rst_n_in,
  input  logic [10:0]       x_in,
  input  logic [9:0]        y_in,
  input  logic              capture_in,
  input  logic              continuous_in,
  input  logic              frame_start_in,
  input  logic              pixel_valid_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [23:0]       rgb_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [7:0]        wr_data_out,
  output logic              bank_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic [1:0]        state_dbg_out
);

  localparam int NPIX = WIDTH*HEIGHT;
  localparam int LAW  = ADDR_W-1;
  localparam int CW   = $clog2(NPIX)+1;

  writer_state_t state, state_next;
  logic [CW-1:0] pix_cnt, cnt_base, cnt_next;
  logic          win_hit, last_px, capturing, take, complete;
  logic          swap_p1, swap_p2;
  logic [LAW-1:0] local_addr;
  logic [11:0]   x_last, y_last;

  logic           s1_hit, s1_bank;
  logic [LAW-1:0] s1_addr;
  logic [23:0]    s1_rgb;

  sprite_window_addr #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(LAW)) u_win (
    .x(x_in), .y(y_in), .h(hcount_in), .v(vcount_in),
    .hit(win_hit), .local_addr(local_addr)
  );

  assign x_last  = {1'b0, x_in} + 12'(WIDTH-1);
  assign y_last  = {2'b00, y_in} + 12'(HEIGHT-1);
  assign last_px = pixel_valid_in && ({1'b0, hcount_in} == x_last) &&
                   ({2'b00, vcount_in} == y_last);
  assign state_dbg_out = state;

  // A frame_start seen while armed or capturing begins a fresh count on that pixel.
  always_comb begin
    capturing  = (state == ST_CAPTURE) || (state == ST_ARMED && frame_start_in);
    take       = capturing && pixel_valid_in && win_hit;
    cnt_base   = frame_start_in ? '0 : pix_cnt;
    cnt_next   = cnt_base;
    if (take && cnt_base != CW'(NPIX)) cnt_next = cnt_base + CW'(1);
    complete   = capturing && last_px && (cnt_next == CW'(NPIX));
    state_next = state;
    case (state)
      ST_IDLE: if (capture_in) state_next = ST_ARMED;
      ST_ARMED, ST_CAPTURE: begin
        if (capturing) begin
          if (last_px) state_next = (complete && !continuous_in) ? ST_IDLE : ST_ARMED;
          else         state_next = ST_CAPTURE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Swap is delayed two stages so it lands the cycle after the final write.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= ST_IDLE;
      pix_cnt        <= '0;
      busy_out       <= 1'b0;
      swap_p1        <= 1'b0;
      swap_p2        <= 1'b0;
      frame_done_out <= 1'b0;
      bank_out       <= 1'b0;
    end else begin
      state          <= state_next;
      busy_out       <= (state_next != ST_IDLE);
      pix_cnt        <= (capturing && !last_px) ? cnt_next : '0;
      swap_p1        <= complete;
      swap_p2        <= swap_p1;
      frame_done_out <= swap_p2;
      if (swap_p2) bank_out <= ~bank_out;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_hit      <= 1'b0;
      s1_bank     <= 1'b0;
      s1_addr     <= '0;
      s1_rgb      <= '0;
      wr_en_out   <= 1'b0;
      wr_addr_out <= '0;
      wr_data_out <= '0;
    end else begin
      s1_hit      <= take;
      s1_bank     <= ~bank_out;
      s1_addr     <= local_addr;
      s1_rgb      <= rgb_in;
      wr_en_out   <= s1_hit;
      wr_data_out <= rgb332(s1_rgb);
      wr_addr_out <= s1_bank ? ADDR_W'(NPIX) + {1'b0, s1_addr} : {1'b0, s1_addr};
    end
  end

endmodule

// File: doc/sprite_image_writer.md
Name: sprite_image_writer

Overview:
- Capture-side counterpart to the palette-indexed sprite renderer.
- Takes a raster RGB888 pixel stream (camera/test pattern) tagged with hcount/vcount, crops a WIDTH x HEIGHT window at (x_in, y_in), and quantizes each pixel to an 8-bit RGB332 palette index.
- Writes the indices into the back bank of the two-bank image BRAM, then swaps banks at frame completion.
- bank_out drives the renderer's bank select, so the renderer always reads a complete frame.

Parameters:
- WIDTH, 256, sprite width in pixels.
- HEIGHT, 256, sprite height in pixels.
- ADDR_W, $clog2(WIDTH*HEIGHT)+1, image BRAM address width covering two banks.

Ports:
- pixel_clk_in  input  1  pixel clock; sole clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- x_in  input  11  left edge of the capture window.
- y_in  input  10  top edge of the capture window.
- capture_in  input  1  single-cycle request to capture the next full frame.
- continuous_in  input  1  when high, re-arm automatically after each completed capture.
- frame_start_in  input  1  single-cycle pulse coincident with pixel (0,0) of each input frame.
- pixel_valid_in  input  1  qualifies hcount_in, vcount_in and rgb_in.
- hcount_in  input  11  column of the incoming pixel.
- vcount_in  input  10  row of the incoming pixel.
- rgb_in  input  24  pixel colour, {R[7:0],G[7:0],B[7:0]}.
- wr_en_out  output  1  image BRAM write enable.
- wr_addr_out  output  ADDR_W  image BRAM write address.
- wr_data_out  output  8  palette index to write.
- bank_out  output  1  display bank for the renderer (drives its bank select).
- busy_out  output  1  high in ARMED or CAPTURE.
- frame_done_out  output  1  one-cycle pulse on bank swap.

Behaviour:
- Reset (async assert, synchronous release): state IDLE; wr_en_out, wr_addr_out, wr_data_out, busy_out, frame_done_out, bank_out all 0; pixel counter 0; pipeline valids cleared.
- FSM states: IDLE, ARMED, CAPTURE.
- IDLE -> ARMED on capture_in.
- ARMED -> CAPTURE on frame_start_in. The frame_start pixel itself is processed as part of the capture.
- CAPTURE -> on the last in-window pixel (h = x_in+WIDTH-1, v = y_in+HEIGHT-1):
  - If the pixel count including that pixel equals WIDTH*HEIGHT: toggle bank_out, pulse frame_done_out, then go to ARMED if continuous_in else IDLE.
  - Otherwise (incomplete frame): no swap, no done pulse, go to ARMED.
- CAPTURE + frame_start_in before completion: treat as a dropped frame. Clear the counter and restart capture within the same state on the new frame; no swap.
- capture_in while busy is ignored.
- capture_in and frame_start_in in the same IDLE cycle: go to ARMED only; capture starts on the following frame.
- Window test: x_in <= h < x_in+WIDTH and y_in <= v < y_in+HEIGHT, evaluated with zero-extended 12-bit arithmetic so the window may extend past 2047 without wrap. Out-of-window or invalid pixels produce no write.
- Pipeline, 2 cycles from pixel_valid_in to wr_en_out:
  - Stage 1 registers the window hit, the local offset (h-x_in, v-y_in) and rgb.
  - Stage 2 registers:
    - wr_data_out = {R[7:5], G[7:5], B[7:6]}
    - wr_addr_out = (~bank_out)*WIDTH*HEIGHT + lx + ly*WIDTH
    - wr_en_out = stage-1 hit AND state CAPTURE at sample time.
- Bank selection: the back bank is sampled at stage 1, so a bank swap never redirects in-flight writes.
- Bank swap timing: bank_out toggles the cycle after the final write's wr_en_out. frame_done_out is high in that same cycle.
- Reset mid-capture: bank_out returns to 0 and in-flight writes are dropped. Partial data left in the back bank is acceptable.
- Pixel counter: $clog2(WIDTH*HEIGHT)+1 bits, saturating at WIDTH*HEIGHT.

Decomposition:
- Package sprite_pkg:
  - writer state enum typedef.
  - rgb332 quantize function.
  - RGB field slice constants.
- One sub-module, sprite_window_addr: combinational window hit plus local offset/address calculation. It is shared with the renderer to keep address mapping identical.

Test Plan:
- Reset and idle: WIDTH=HEIGHT=4, rst_n_in low mid-stream -> all outputs 0 immediately; no wr_en_out without capture_in.
- Full capture: x_in=2, y_in=1, raster 8x6, rgb_in = {h*32, v*32, 8'hC0}, capture_in then frame_start_in:
  - exactly 16 writes, addrs 16..31, first wr_data_out = {3'b010, 3'b001, 2'b11}, 2 cycles after pixel (2,1);
  - bank_out 0->1 one cycle after the last write, with frame_done_out for one cycle.
- Continuous mode: continuous_in=1 over 3 frames -> writes alternate addr ranges 16..31, 0..15, 16..31; bank_out toggles 3 times.
- Dropped frame: frame_start_in pulsed after 10 in-window pixels -> no swap, no done pulse; the next full frame completes with 16 writes and swaps.
- Edge window: x_in=2046, WIDTH=4 -> only h = 2046 and 2047 hit; no wrap to h = 0 or 1; count < 16, so no swap.
- Simultaneous capture_in + frame_start_in in IDLE -> no writes in that frame; capture on the next frame.
